// File: rtl/count_mod_pkg.sv
// Shared constants and helpers for the count_mod counter family.
// Mode/direction encodings and prescaler width sizing.
package count_mod_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int cnt_width(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/count_prescale.sv
// Enable prescaler: asserts tick on every PRESCALE-th enabled cycle.
// PRESCALE=1 collapses to tick=e with no state.
module count_prescale
  import count_mod_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic resetn,
  input  logic e,
  input  logic sclr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_direct
      logic unused_in;
      assign unused_in = ^{clock, resetn, sclr};
      assign tick = e;
    end else begin : g_count
      localparam int W = cnt_width(PRESCALE);
      localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

      logic [W-1:0] cnt;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          cnt <= '0;
        end else if (sclr) begin
          cnt <= '0;
        end else if (e) begin
          cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
      end

      assign tick = e && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/count_mod.sv
// Parametrised up/down modulo counter with clear, clamped load,
// wrap/saturate boundary handling, registered tc pulse and sticky ovf.
module count_mod
  import count_mod_pkg::*;
#(
  parameter int N        = 8,
  parameter int MODULO   = 256,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         e,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         ovf
);

  // MODULO-1 always fits in N bits, so MODULO=2**N compares against all-ones.
  localparam logic [N-1:0] QMAX = N'(MODULO - 1);

  logic         tick;
  logic [N-1:0] q_nxt;
  logic         tc_nxt;
  logic         ovf_nxt;
  logic         bnd;

  count_prescale #(
    .PRESCALE(PRESCALE)
  ) u_prescale (
    .clock (clock),
    .resetn(resetn),
    .e     (e),
    .sclr  (clr | load),
    .tick  (tick)
  );

  always_comb begin
    q_nxt   = q;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf;
    bnd     = 1'b0;
    if (clr) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (load) begin
      q_nxt = (d > QMAX) ? QMAX : d;
    end else if (tick) begin
      if (up == DIR_UP) begin
        if (q == QMAX) begin
          bnd = 1'b1;
          if (SATURATE == MODE_WRAP) q_nxt = '0;
        end else begin
          q_nxt = q + N'(1);
        end
      end else begin
        if (q == '0) begin
          bnd = 1'b1;
          if (SATURATE == MODE_WRAP) q_nxt = QMAX;
        end else begin
          q_nxt = q - N'(1);
        end
      end
      if (bnd) begin
        tc_nxt  = 1'b1;
        ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      tc  <= tc_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_count_mod.sv
// Scoreboard bench for count_mod: four configurations driven in parallel,
// expected values from an integer reference model queued per edge.
module tb_count_mod;

  logic       clock = 1'b0;
  logic       resetn, e, up, clr, load;
  logic [3:0] d;

  logic [3:0] q0, q1, q2;
  logic [2:0] q3;
  logic       tc0, tc1, tc2, tc3;
  logic       ovf0, ovf1, ovf2, ovf3;

  always #5 clock = ~clock;

  // 0: wrap P1, 1: saturate P1, 2: wrap P3, 3: N=3 MODULO=8 (full range) P2
  count_mod #(.N(4), .MODULO(10), .PRESCALE(1), .SATURATE(0)) u0 (
    .clock(clock), .resetn(resetn), .e(e), .up(up), .clr(clr), .load(load),
    .d(d), .q(q0), .tc(tc0), .ovf(ovf0));
  count_mod #(.N(4), .MODULO(10), .PRESCALE(1), .SATURATE(1)) u1 (
    .clock(clock), .resetn(resetn), .e(e), .up(up), .clr(clr), .load(load),
    .d(d), .q(q1), .tc(tc1), .ovf(ovf1));
  count_mod #(.N(4), .MODULO(10), .PRESCALE(3), .SATURATE(0)) u2 (
    .clock(clock), .resetn(resetn), .e(e), .up(up), .clr(clr), .load(load),
    .d(d), .q(q2), .tc(tc2), .ovf(ovf2));
  count_mod #(.N(3), .MODULO(8), .PRESCALE(2), .SATURATE(0)) u3 (
    .clock(clock), .resetn(resetn), .e(e), .up(up), .clr(clr), .load(load),
    .d(d[2:0]), .q(q3), .tc(tc3), .ovf(ovf3));

  int mm[4]  = '{10, 10, 10, 8};
  int nb[4]  = '{4, 4, 4, 3};
  int ps[4]  = '{1, 1, 3, 2};
  int sat[4] = '{0, 1, 0, 0};

  int mq[4];
  int mpre[4];
  bit mtc[4];
  bit movf[4];

  typedef struct packed {
    logic [3:0][3:0] q;
    logic [3:0]      tc;
    logic [3:0]      ovf;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  logic [3:0] aq[4];
  logic       atc[4];
  logic       aovf[4];
  assign aq[0] = q0;  assign aq[1] = q1;  assign aq[2] = q2;  assign aq[3] = {1'b0, q3};
  assign atc[0] = tc0; assign atc[1] = tc1; assign atc[2] = tc2; assign atc[3] = tc3;
  assign aovf[0] = ovf0; assign aovf[1] = ovf1; assign aovf[2] = ovf2; assign aovf[3] = ovf3;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0d expected=%0d t=%0t", nm, idx, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0; mpre[i] = 0; mtc[i] = 0; movf[i] = 0;
    end
  endfunction

  // One rising edge of every configuration, written from the behavioural rules.
  function automatic void model_step();
    int dv;
    bit tick;
    if (!resetn) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      dv = int'(d) % (1 << nb[i]);
      mtc[i] = 0;
      if (clr) begin
        mq[i] = 0; movf[i] = 0; mpre[i] = 0;
      end else if (load) begin
        mq[i] = (dv > mm[i] - 1) ? mm[i] - 1 : dv;
        mpre[i] = 0;
      end else if (e) begin
        mpre[i]++;
        tick = (mpre[i] == ps[i]);
        if (tick) mpre[i] = 0;
        if (tick) begin
          if (up && mq[i] < mm[i] - 1)      mq[i]++;
          else if (!up && mq[i] > 0)        mq[i]--;
          else begin
            mtc[i] = 1; movf[i] = 1;
            if (sat[i] == 0) mq[i] = up ? 0 : mm[i] - 1;
          end
        end
      end
    end
  endfunction

  function automatic void push_exp();
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      x.q[i]   = 4'(mq[i]);
      x.tc[i]  = mtc[i];
      x.ovf[i] = movf[i];
    end
    sb.push_back(x);
  endfunction

  task automatic step(input bit e_, input bit up_, input bit clr_, input bit load_, input int d_);
    @(negedge clock);
    e = e_; up = up_; clr = clr_; load = load_; d = 4'(d_);
    model_step();
    push_exp();
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("async_rst_q", i, int'(aq[i]), 0);
      chk("async_rst_tc", i, int'(atc[i]), 0);
      chk("async_rst_ovf", i, int'(aovf[i]), 0);
    end
    #1 resetn = 1'b1;
    model_reset();
    model_step();
    push_exp();
  endtask

  always @(posedge clock) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk("q", i, int'(aq[i]), int'(x.q[i]));
        chk("tc", i, int'(atc[i]), int'(x.tc[i]));
        chk("ovf", i, int'(aovf[i]), int'(x.ovf[i]));
      end
    end
  end

  initial begin
    resetn = 1'b0; e = 0; up = 1; clr = 0; load = 0; d = 0;
    model_reset();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    resetn = 1'b1;

    // count up, async reset mid-count, resume from 0
    for (int k = 0; k < 6; k++) step(1, 1, 0, 0, 0);
    reset_pulse();
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0);

    // up wrap then clear
    step(0, 1, 0, 1, 8);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);

    // down wrap
    step(0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);

    // load clamp and priority
    step(0, 1, 0, 1, 13);
    step(1, 1, 1, 1, 5);
    step(0, 1, 0, 1, 4);

    // saturate run then step back down
    step(0, 1, 0, 1, 8);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // prescaled counting with enable gaps and mid-period load
    step(0, 1, 1, 0, 0);
    for (int k = 0; k < 7; k++) step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 2);
    for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        step($urandom_range(0, 9) < 8,
             (k % 60) < 35 ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2),
             $urandom_range(0, 49) == 0,
             $urandom_range(0, 14) == 0,
             int'($urandom_range(0, 15)));
      end
    end

    @(posedge clock);
    #2;
    chk("sb_drained", 0, sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
